// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared types, defaults and address check for the fetch stage
package ifetch_pkg;

  // Fetch stage control states
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
  localparam int unsigned DEF_IMEM_BYTES = 400;

  // A fetch address is usable only if word aligned and the whole word lies inside
  // memory; the 33-bit sum keeps addresses near 2^32 from wrapping into range.
  function automatic logic addr_legal(input logic [31:0] addr, input logic [32:0] imem_bytes);
    logic [32:0] w_end;
    w_end = {1'b0, addr} + 33'd4;
    return (addr[1:0] == 2'b00) && (w_end <= imem_bytes);
  endfunction

endpackage

// File: rtl/ifetch.sv
// rtl/ifetch.sv - single-stage instruction fetch with stall, redirect and sticky address fault
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter int unsigned IMEM_BYTES = DEF_IMEM_BYTES
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_ins,
  output logic [31:0] out_pc,
  output logic        fault,
  output logic [31:0] fault_pc
);

  localparam logic [32:0] LP_IMEM_BYTES = 33'(IMEM_BYTES);

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_out_valid;
  logic [31:0] r_out_ins;
  logic [31:0] r_out_pc;
  logic        r_fault;
  logic [31:0] r_fault_pc;

  logic        w_advance;
  logic        w_pc_legal;
  logic        w_redirect_legal;

  // Decode slot is free (empty or being consumed) and no redirect is pending
  assign w_advance        = (!r_out_valid || out_ready) && !redirect_valid;
  assign w_pc_legal       = addr_legal(r_pc, LP_IMEM_BYTES);
  assign w_redirect_legal = addr_legal(redirect_pc, LP_IMEM_BYTES);

  // Control FSM plus the single output register set; a redirect beats both advance and stall
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_BOOT;
      r_pc        <= RESET_PC;
      r_out_valid <= 1'b0;
      r_out_ins   <= 32'h0;
      r_out_pc    <= 32'h0;
      r_fault     <= 1'b0;
      r_fault_pc  <= 32'h0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (redirect_valid) begin
            r_out_valid <= 1'b0;
            if (w_redirect_legal) begin
              r_pc <= redirect_pc;
            end else begin
              r_state    <= ST_FAULT;
              r_fault    <= 1'b1;
              r_fault_pc <= redirect_pc;
            end
          end else if (w_advance) begin
            if (w_pc_legal) begin
              r_out_ins   <= imem_data;
              r_out_pc    <= r_pc;
              r_out_valid <= 1'b1;
              r_pc        <= r_pc + 32'd4;
            end else begin
              r_state     <= ST_FAULT;
              r_fault     <= 1'b1;
              r_fault_pc  <= r_pc;
              r_out_valid <= 1'b0;
            end
          end
        end
        ST_FAULT: begin
          r_out_valid <= 1'b0;
        end
        default: begin
          r_state <= ST_BOOT;
        end
      endcase
    end
  end

  assign imem_addr = r_pc;
  assign out_valid = r_out_valid;
  assign out_ins   = r_out_ins;
  assign out_pc    = r_out_pc;
  assign fault     = r_fault;
  assign fault_pc  = r_fault_pc;

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - self-checking bench for ifetch against a behavioural fetch model
module tb_ifetch;

  localparam int unsigned NBYTES = 400;
  localparam int unsigned NWORDS = NBYTES / 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_ins;
  logic [31:0] out_pc;
  logic        fault;
  logic [31:0] fault_pc;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic        chk_en = 1'b0;

  logic [31:0] mem [NWORDS];

  always #5 clk = ~clk;

  ifetch #(.RESET_PC(32'h0), .IMEM_BYTES(NBYTES)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_ins        (out_ins),
    .out_pc         (out_pc),
    .fault          (fault),
    .fault_pc       (fault_pc)
  );

  // Memory answers combinationally; outside the array it returns junk that must never be captured
  assign imem_data = (imem_addr < NBYTES) ? mem[imem_addr / 4] : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  function automatic bit legal(input logic [31:0] a);
    longint unsigned la;
    la = longint'(a);
    return (la % 4 == 0) && (la + 4 <= NBYTES);
  endfunction

  // Behavioural model: what decode should see, updated once per clock from the sampled inputs
  bit          m_booting = 1'b1;
  bit          m_faulted = 1'b0;
  logic [31:0] m_pc = 32'h0;
  bit          m_valid = 1'b0;
  logic [31:0] m_ins = 32'h0;
  logic [31:0] m_opc = 32'h0;
  logic [31:0] m_fpc = 32'h0;

  always @(posedge clk) begin
    if (rst) begin
      m_booting = 1; m_faulted = 0; m_pc = 32'h0; m_valid = 0;
      m_ins = 32'h0; m_opc = 32'h0; m_fpc = 32'h0;
    end else if (m_booting) begin
      m_booting = 0;
    end else if (!m_faulted) begin
      if (redirect_valid) begin
        m_valid = 0;
        if (legal(redirect_pc)) m_pc = redirect_pc;
        else begin m_faulted = 1; m_fpc = redirect_pc; end
      end else if (!m_valid || out_ready) begin
        if (legal(m_pc)) begin
          m_ins = mem[m_pc / 4]; m_opc = m_pc; m_valid = 1; m_pc = m_pc + 4;
        end else begin
          m_faulted = 1; m_fpc = m_pc; m_valid = 0;
        end
      end
    end
  end

  // Cycle-by-cycle comparison, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_out_valid", {31'b0, out_valid}, {31'b0, m_valid});
      chk("model_out_ins", out_ins, m_ins);
      chk("model_out_pc", out_pc, m_opc);
      chk("model_fault", {31'b0, fault}, {31'b0, m_faulted});
      chk("model_fault_pc", fault_pc, m_fpc);
      if (!m_faulted) chk("model_imem_addr", imem_addr, m_pc);
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    mem[0] = 32'h0080_006F;
    mem[1] = 32'h00A0_0093;
    mem[2] = 32'h00F0_0113;
    mem[3] = 32'h0040_8093;
    mem[4] = 32'hFF9F_F06F;
    for (int i = 5; i < NWORDS; i++) mem[i] = $urandom;

    // Reset state
    cyc(); cyc();
    chk_en = 1'b1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_fault", {31'b0, fault}, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_ins", out_ins, 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0);

    // Straight-line fetch, first valid two cycles after reset falls
    rst = 1'b0;
    cyc();
    chk("boot_no_valid", {31'b0, out_valid}, 32'h0);
    cyc();
    chk("first_valid", {31'b0, out_valid}, 32'h1);
    chk("first_pc", out_pc, 32'h0);
    chk("first_ins", out_ins, 32'h0080_006F);
    cyc();
    chk("second_pc", out_pc, 32'h4);

    // Stall three cycles while pc 4 is presented
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_ins", out_ins, 32'h00A0_0093);
      chk("stall_pc", out_pc, 32'h4);
      chk("stall_imem_addr", imem_addr, 32'h8);
    end
    out_ready = 1'b1;
    cyc();
    chk("after_stall_pc", out_pc, 32'h8);
    cyc();
    chk("pc12", out_pc, 32'hC);
    chk("ins12", out_ins, 32'h0040_8093);
    cyc();
    chk("pc16", out_pc, 32'h10);
    chk("ins16", out_ins, 32'hFF9F_F06F);

    // Redirect back to 8 while 16 is presented
    redirect_valid = 1'b1; redirect_pc = 32'h8;
    cyc();
    redirect_valid = 1'b0;
    chk("redir_bubble", {31'b0, out_valid}, 32'h0);
    cyc();
    chk("redir_valid", {31'b0, out_valid}, 32'h1);
    chk("redir_pc", out_pc, 32'h8);
    chk("redir_ins", out_ins, 32'h00F0_0113);

    // Run off the top of memory
    redirect_valid = 1'b1; redirect_pc = 32'd392;
    cyc();
    redirect_valid = 1'b0;
    cyc();
    chk("top_pc392", out_pc, 32'd392);
    chk("top_valid392", {31'b0, out_valid}, 32'h1);
    cyc();
    chk("top_pc396", out_pc, 32'd396);
    cyc();
    chk("top_fault", {31'b0, fault}, 32'h1);
    chk("top_fault_pc", fault_pc, 32'd400);
    chk("top_no_valid", {31'b0, out_valid}, 32'h0);

    // Misaligned redirect, fault stays put despite further redirects
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc(); cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h6;
    cyc();
    chk("mis_fault", {31'b0, fault}, 32'h1);
    chk("mis_fault_pc", fault_pc, 32'h6);
    redirect_pc = 32'h0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("mis_hold_fault", {31'b0, fault}, 32'h1);
      chk("mis_hold_fpc", fault_pc, 32'h6);
      chk("mis_hold_valid", {31'b0, out_valid}, 32'h0);
    end
    redirect_valid = 1'b0;
    rst = 1'b1;
    cyc();
    chk("mis_cleared", {31'b0, fault}, 32'h0);
    chk("mis_cleared_fpc", fault_pc, 32'h0);

    // Reset during stall with a pending redirect
    rst = 1'b0;
    cyc(); cyc();
    out_ready = 1'b0;
    cyc();
    redirect_valid = 1'b1; redirect_pc = 32'hC; rst = 1'b1;
    cyc();
    chk("rs_valid", {31'b0, out_valid}, 32'h0);
    chk("rs_ins", out_ins, 32'h0);
    chk("rs_pc", out_pc, 32'h0);
    chk("rs_fault", {31'b0, fault}, 32'h0);
    chk("rs_fault_pc", fault_pc, 32'h0);
    chk("rs_imem_addr", imem_addr, 32'h0);
    rst = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;

    // Randomised traffic checked only by the model
    for (int i = 0; i < 3000; i++) begin
      cyc();
      rst            = ($urandom_range(0, 63) == 0);
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 5))
        0, 1, 2: redirect_pc = 32'($urandom_range(0, NWORDS - 1)) * 4;
        3:       redirect_pc = ($urandom_range(0, 1) != 0) ? 32'd392 : 32'd396;
        4:       redirect_pc = 32'($urandom_range(0, NBYTES - 1));
        default: redirect_pc = $urandom;
      endcase
    end
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter IMEM_BYTES, default 400, instruction memory capacity in bytes.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 imem_addr  output  32  byte address to instruction memory; equals the internal pc register.
REQ-006 imem_data  input  32  little-endian instruction word at imem_addr, valid combinationally in the same cycle.
REQ-007 redirect_valid  input  1  control-flow redirect request (jal/branch taken).
REQ-008 redirect_pc  input  32  redirect target byte address.
REQ-009 out_valid  output  1  fetched instruction available to decode.
REQ-010 out_ready  input  1  decode accepts out_ins/out_pc this cycle.
REQ-011 out_ins  output  32  fetched instruction word.
REQ-012 out_pc  output  32  byte address of out_ins.
REQ-013 fault  output  1  sticky fetch-address fault.
REQ-014 fault_pc  output  32  offending address when fault=1, else 0.

Function
REQ-015 FSM states SHALL be BOOT, RUN, FAULT; reset enters BOOT.
REQ-016 BOOT SHALL last exactly one cycle: no capture, pc held at RESET_PC, then RUN.
REQ-017 An address is legal iff addr[1:0]==0 and addr+4 <= IMEM_BYTES (unsigned, 33-bit compare).
REQ-018 In RUN, "advance" SHALL occur when out_valid==0 or out_ready==1, and redirect_valid==0.
REQ-019 On advance with pc legal: out_ins<=imem_data, out_pc<=pc, out_valid<=1, pc<=pc+4.
REQ-020 On advance with pc illegal: go FAULT, fault_pc<=pc, out_valid<=0, no capture.
REQ-021 Stall (out_valid==1, out_ready==0, no redirect): out_ins, out_pc, out_valid, pc all held; imem_addr stable.
REQ-022 redirect_valid in RUN SHALL take priority over advance and stall: out_valid<=0 (held instruction dropped), pc<=redirect_pc.
REQ-023 Illegal redirect_pc SHALL go FAULT with fault_pc<=redirect_pc, out_valid<=0.
REQ-024 Latency: instruction at pc appears on out_ins one cycle after pc is on imem_addr; redirect in cycle N gives first target out_valid in cycle N+2.
REQ-025 Throughput: one instruction per cycle while out_ready==1.
REQ-026 In FAULT: out_valid=0, fault=1, pc held, redirect_valid and out_ready ignored; exit only by rst.
REQ-027 pc+4 SHALL wrap modulo 2^32; wrapped value is then caught by REQ-017.

Reset
REQ-028 rst SHALL override all other inputs in the same cycle, including mid-stall and mid-redirect.
REQ-029 Reset values: pc=RESET_PC, out_valid=0, out_ins=0, out_pc=0, fault=0, fault_pc=0, state=BOOT.

Structure
REQ-030 Package ifetch_pkg SHALL hold the state enum, RESET_PC and IMEM_BYTES defaults, and the address-legality function.
REQ-031 No sub-module; single flat module with one state register and one output register set.

Verification
REQ-032 Reset, out_ready=1, memory {0x0080006F,0x00A00093,0x00F00113,0x00408093,0xFF9FF06F} -> out_valid first high 2 cycles after rst falls; out_pc 0,4,8,12,16 on consecutive cycles with those words.
REQ-033 out_ready=0 for 3 cycles while out_pc=4 -> out_ins held 0x00A00093, imem_addr held 8; after release out_pc=8 next cycle.
REQ-034 redirect_valid=1, redirect_pc=8 while out_pc=16 -> next cycle out_valid=0, following cycle out_pc=8/out_ins=0x00F00113; out_pc=20 never seen.
REQ-035 redirect_pc=0x6 -> fault=1, fault_pc=6, out_valid=0; holds for 10 cycles despite redirect to 0; clears only on rst.
REQ-036 Redirect to 392, out_ready=1 -> out_pc 392 then 396 valid, then fault=1, fault_pc=400.
REQ-037 rst asserted during stall with pending redirect -> next cycle all REQ-029 values, imem_addr=RESET_PC.
